// File: rtl/spi_target.sv
// spi_target: SPI mode-0 target, all pins oversampled in the clk domain.
// Received bytes feed a show-ahead RX FIFO; one holding register feeds TX.
module spi_target #(
    parameter int         RX_DEPTH  = 4,
    parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       ssn,
    input  logic       mosi,
    output logic       miso,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_pop,
    output logic       rx_overrun,
    input  logic       rx_ovr_clr,
    output logic       busy
);

    localparam int          AW       = $clog2(RX_DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(RX_DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [2:0] sclk_sr;
    logic [2:0] ssn_sr;
    logic [1:0] mosi_sr;

    logic sclk_s;
    logic sclk_h;
    logic ssn_s;
    logic ssn_h;
    logic mosi_s;

    logic sel;
    logic sclk_rise;
    logic sclk_fall;
    logic ssn_fall;
    logic ssn_rise;
    logic rx_ev;
    logic tx_ev;
    logic byte_done;
    logic reload;
    logic shift_only;

    logic [2:0] bit_cnt;
    logic [6:0] rx_shift;
    logic [7:0] rx_byte;
    logic [7:0] tx_shift;
    logic [7:0] tx_hold;
    logic       tx_full;

    logic [7:0]    mem [RX_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          fifo_full;
    logic          do_pop;
    logic          do_push;
    logic          drop;

    // Two sync flops per pin plus a history flop on sclk and ssn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sr <= 3'b000;
            ssn_sr  <= 3'b111;
            mosi_sr <= 2'b00;
        end else begin
            sclk_sr <= {sclk_sr[1:0], sclk};
            ssn_sr  <= {ssn_sr[1:0], ssn};
            mosi_sr <= {mosi_sr[0], mosi};
        end
    end

    assign sclk_s = sclk_sr[1];
    assign sclk_h = sclk_sr[2];
    assign ssn_s  = ssn_sr[1];
    assign ssn_h  = ssn_sr[2];
    assign mosi_s = mosi_sr[1];

    assign sel        = ~ssn_s;
    assign sclk_rise  = sclk_s & ~sclk_h;
    assign sclk_fall  = ~sclk_s & sclk_h;
    assign ssn_fall   = ~ssn_s & ssn_h;
    assign ssn_rise   = ssn_s & ~ssn_h;
    assign rx_ev      = sel & sclk_rise;
    assign tx_ev      = sel & sclk_fall;
    assign byte_done  = rx_ev & (bit_cnt == 3'd7);
    assign reload     = ssn_fall | (tx_ev & (bit_cnt == 3'd0));
    assign shift_only = tx_ev & ~ssn_fall & (bit_cnt != 3'd0);
    assign rx_byte    = {rx_shift, mosi_s};

    // Bit counter: cleared at select edges, wraps 7->0 on each full byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= 3'd0;
        end else if (ssn_fall || ssn_rise) begin
            bit_cnt <= 3'd0;
        end else if (rx_ev) begin
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // Receive shifter; the eighth bit goes straight to the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_shift <= 7'd0;
        end else if (rx_ev) begin
            rx_shift <= {rx_shift[5:0], mosi_s};
        end
    end

    // Transmit shifter: reload at byte boundaries, else shift MSB-first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift <= IDLE_BYTE;
        end else if (reload) begin
            tx_shift <= tx_full ? tx_hold : IDLE_BYTE;
        end else if (shift_only) begin
            tx_shift <= {tx_shift[6:0], 1'b0};
        end
    end

    // Holding register; a reload drains it before a new load can land.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_hold <= 8'h00;
            tx_full <= 1'b0;
        end else begin
            if (tx_load && !tx_full) begin
                tx_hold <= tx_data;
            end
            if (reload && tx_full) begin
                tx_full <= 1'b0;
            end else if (tx_load && !tx_full) begin
                tx_full <= 1'b1;
            end
        end
    end

    assign fifo_full = (count == CNT_FULL);
    assign do_pop    = rx_pop & (count != '0);
    assign do_push   = byte_done & (~fifo_full | do_pop);
    assign drop      = byte_done & fifo_full & ~do_pop;

    // RX FIFO storage and pointers; a pop frees room for a same-cycle push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RX_DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= rx_byte;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_ONE;
            end else if (do_pop && !do_push) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // Sticky overrun; a drop in the clear cycle keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_overrun <= 1'b0;
        end else if (drop) begin
            rx_overrun <= 1'b1;
        end else if (rx_ovr_clr) begin
            rx_overrun <= 1'b0;
        end
    end

    assign rx_data  = mem[rd_ptr];
    assign rx_valid = (count != '0);
    assign tx_ready = ~tx_full;
    assign busy     = sel;
    assign miso     = sel & tx_shift[7];

endmodule
